// File: rtl/spi_input_conditioner_if.sv
// Pin-side bundle of the SPI input conditioner: raw asynchronous pins in,
// filtered levels and single-cycle edge pulses out.
interface spi_input_conditioner_if;
    logic sclk_in;
    logic cs_in;
    logic mosi_in;
    logic sclk_cond;
    logic sclk_posedge;
    logic sclk_negedge;
    logic cs_cond;
    logic cs_fall;
    logic cs_rise;
    logic mosi_cond;

    modport master (
        output sclk_in, cs_in, mosi_in,
        input  sclk_cond, sclk_posedge, sclk_negedge,
        input  cs_cond, cs_fall, cs_rise, mosi_cond
    );

    modport slave (
        input  sclk_in, cs_in, mosi_in,
        output sclk_cond, sclk_posedge, sclk_negedge,
        output cs_cond, cs_fall, cs_rise, mosi_cond
    );
endinterface

// File: rtl/spi_input_conditioner.sv
// Synchronizes and glitch-filters SCLK, CS and MOSI into clean levels, with
// registered one-cycle edge pulses for SCLK and CS.
module spi_input_conditioner #(
    parameter int WAIT_TIME = 3,
    parameter int CNT_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    spi_input_conditioner_if.slave  pins
);
    // Channel index: 0 = SCLK, 1 = CS, 2 = MOSI. CS idles high (active-low pin).
    localparam logic [2:0]           IDLE_LVL = 3'b010;
    localparam logic [CNT_WIDTH-1:0] WAIT_CNT = CNT_WIDTH'(WAIT_TIME);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

    logic [2:0]           raw_s;
    logic [2:0]           sync0_q;
    logic [2:0]           sync1_q;
    logic [2:0]           cond_q;
    logic [2:0]           cond_d;
    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic [CNT_WIDTH-1:0] cnt_d [3];
    logic [1:0]           rise_q;
    logic [1:0]           rise_d;
    logic [1:0]           fall_q;
    logic [1:0]           fall_d;

    assign raw_s = {pins.mosi_in, pins.cs_in, pins.sclk_in};

    // Stability filter: a disagreement must persist WAIT_TIME+1 cycles to be accepted
    always_comb begin
        cond_d = cond_q;
        cnt_d  = cnt_q;
        for (int ch = 0; ch < 3; ch++) begin
            if (sync1_q[ch] == cond_q[ch]) begin
                cnt_d[ch] = CNT_ZERO;
            end else if (cnt_q[ch] == WAIT_CNT) begin
                cond_d[ch] = sync1_q[ch];
                cnt_d[ch]  = CNT_ZERO;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end
        end
        for (int ch = 0; ch < 2; ch++) begin
            rise_d[ch] = cond_d[ch] & ~cond_q[ch];
            fall_d[ch] = ~cond_d[ch] & cond_q[ch];
        end
    end

    // State registers; pulses are registered alongside the level they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= IDLE_LVL;
            sync1_q <= IDLE_LVL;
            cond_q  <= IDLE_LVL;
            rise_q  <= 2'b00;
            fall_q  <= 2'b00;
            for (int ch = 0; ch < 3; ch++) begin
                cnt_q[ch] <= CNT_ZERO;
            end
        end else begin
            sync0_q <= raw_s;
            sync1_q <= sync0_q;
            cond_q  <= cond_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int ch = 0; ch < 3; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign pins.sclk_cond    = cond_q[0];
    assign pins.sclk_posedge = rise_q[0];
    assign pins.sclk_negedge = fall_q[0];
    assign pins.cs_cond      = cond_q[1];
    assign pins.cs_fall      = fall_q[1];
    assign pins.cs_rise      = rise_q[1];
    assign pins.mosi_cond    = cond_q[2];

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Self-checking bench for spi_input_conditioner: expected pulse events are
// queued with their due cycle when stimulus is driven, then matched to observed pulses.
`timescale 1ns/1ps
module tb_spi_input_conditioner;
    localparam int WAIT_TIME = 3;
    localparam int LAT       = WAIT_TIME + 3;
    localparam int K_SPOS = 0, K_SNEG = 1, K_CFALL = 2, K_CRISE = 3;

    typedef struct {
        int   kind;
        int   cyc;
        logic mosi;
        logic chk_mosi;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    spi_input_conditioner_if bus();

    spi_input_conditioner #(.WAIT_TIME(WAIT_TIME), .CNT_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .pins  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every pulse with the cycle it appears and the MOSI level at that moment
    always @(negedge clk) begin
        if (bus.sclk_posedge === 1'b1) obs_q.push_back('{kind: K_SPOS,  cyc: cyc, mosi: bus.mosi_cond, chk_mosi: 1'b0});
        if (bus.sclk_negedge === 1'b1) obs_q.push_back('{kind: K_SNEG,  cyc: cyc, mosi: bus.mosi_cond, chk_mosi: 1'b0});
        if (bus.cs_fall === 1'b1)      obs_q.push_back('{kind: K_CFALL, cyc: cyc, mosi: bus.mosi_cond, chk_mosi: 1'b0});
        if (bus.cs_rise === 1'b1)      obs_q.push_back('{kind: K_CRISE, cyc: cyc, mosi: bus.mosi_cond, chk_mosi: 1'b0});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int kind, input int at, input logic mosi, input logic chk);
        exp_q.push_back('{kind: kind, cyc: at, mosi: mosi, chk_mosi: chk});
    endtask

    task automatic test_reset();
        logic [6:0] got;
        reset = 1'b1;
        bus.sclk_in = 1'b0; bus.cs_in = 1'b1; bus.mosi_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.sclk_in = ~bus.sclk_in; bus.cs_in = ~bus.cs_in; bus.mosi_in = ~bus.mosi_in;
            got = {bus.sclk_cond, bus.cs_cond, bus.mosi_cond, bus.sclk_posedge,
                   bus.sclk_negedge, bus.cs_fall, bus.cs_rise};
            n_cmp++;
            if (got !== 7'b0100000) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %b, expected %b", i, got, 7'b0100000);
            end
        end
        @(negedge clk);
        bus.sclk_in = 1'b0; bus.cs_in = 1'b1; bus.mosi_in = 1'b0;
        reset = 1'b0;
        step(1);
        got = {bus.sclk_cond, bus.cs_cond, bus.mosi_cond, bus.sclk_posedge,
               bus.sclk_negedge, bus.cs_fall, bus.cs_rise};
        n_cmp++;
        if (got !== 7'b0100000) begin
            n_bad++;
            $display("FAIL reset_release: got %b, expected %b", got, 7'b0100000);
        end
        step(LAT + 2);
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clean_edge();
        ev_t e, o;
        int  t0 = cyc;
        bus.cs_in = 1'b0;
        expect_ev(K_CFALL, t0 + LAT, 1'b0, 1'b0);
        step(LAT - 1);
        n_cmp++;
        if (bus.cs_cond !== 1'b1) begin
            n_bad++; $display("FAIL clean_edge_early: cs_cond got %b, expected 1", bus.cs_cond);
        end
        step(1);
        n_cmp++;
        if (bus.cs_cond !== 1'b0) begin
            n_bad++; $display("FAIL clean_edge_level: cs_cond got %b, expected 0", bus.cs_cond);
        end
        step(4);
        t0 = cyc;
        bus.cs_in = 1'b1;
        expect_ev(K_CRISE, t0 + LAT, 1'b0, 1'b0);
        step(LAT + 3);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL clean_edge_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                n_bad++; $display("FAIL clean_edge_ev: got kind %0d @%0d, expected kind %0d @%0d", o.kind, o.cyc, e.kind, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch();
        ev_t e, o;
        int  widths[3] = '{WAIT_TIME, WAIT_TIME + 1, WAIT_TIME + 2};
        for (int k = 0; k < 3; k++) begin
            int t0 = cyc;
            bus.sclk_in = 1'b1;
            if (widths[k] > WAIT_TIME) begin
                expect_ev(K_SPOS, t0 + LAT, 1'b0, 1'b0);
                expect_ev(K_SNEG, t0 + widths[k] + LAT, 1'b0, 1'b0);
            end
            step(widths[k]);
            bus.sclk_in = 1'b0;
            step(LAT + 4);
            n_cmp++;
            if (bus.sclk_cond !== 1'b0) begin
                n_bad++; $display("FAIL glitch_level[w=%0d]: sclk_cond got %b, expected 0", widths[k], bus.sclk_cond);
            end
            n_cmp++;
            if (obs_q.size() !== exp_q.size()) begin
                n_bad++; $display("FAIL glitch_count[w=%0d]: got %0d events, expected %0d", widths[k], obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    n_bad++; $display("FAIL glitch_ev[w=%0d]: got kind %0d @%0d, expected kind %0d @%0d", widths[k], o.kind, o.cyc, e.kind, e.cyc);
                end
            end
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_spi_frame();
        ev_t         e, o;
        logic [15:0] data = 16'hA53C;
        int          t0 = cyc;
        bus.cs_in = 1'b0; bus.sclk_in = 1'b0; bus.mosi_in = data[15];
        expect_ev(K_CFALL, t0 + LAT, 1'b0, 1'b0);
        step(5);
        for (int i = 0; i < 16; i++) begin
            t0 = cyc;
            bus.sclk_in = 1'b1;
            expect_ev(K_SPOS, t0 + LAT, data[15 - i], 1'b1);
            step(5);
            bus.sclk_in = 1'b0;
            expect_ev(K_SNEG, t0 + 5 + LAT, 1'b0, 1'b0);
            if (i < 15) bus.mosi_in = data[14 - i];
            step(5);
        end
        t0 = cyc;
        bus.cs_in = 1'b1; bus.mosi_in = 1'b0;
        expect_ev(K_CRISE, t0 + LAT, 1'b0, 1'b0);
        step(LAT + 4);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL frame_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.kind !== e.kind || o.cyc !== e.cyc || (e.chk_mosi && o.mosi !== e.mosi)) begin
                n_bad++;
                $display("FAIL frame_ev[%0d]: got kind %0d @%0d mosi %b, expected kind %0d @%0d mosi %b",
                         i, o.kind, o.cyc, o.mosi, e.kind, e.cyc, e.mosi);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_simultaneous();
        ev_t e, o;
        int  t0 = cyc;
        bus.cs_in = 1'b0; bus.sclk_in = 1'b1;
        expect_ev(K_SPOS, t0 + LAT, 1'b0, 1'b0);
        expect_ev(K_CFALL, t0 + LAT, 1'b0, 1'b0);
        step(10);
        t0 = cyc;
        bus.cs_in = 1'b1; bus.sclk_in = 1'b0;
        expect_ev(K_SNEG, t0 + LAT, 1'b0, 1'b0);
        expect_ev(K_CRISE, t0 + LAT, 1'b0, 1'b0);
        step(LAT + 4);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL simul_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                n_bad++; $display("FAIL simul_ev: got kind %0d @%0d, expected kind %0d @%0d", o.kind, o.cyc, e.kind, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_filter();
        int t0 = cyc;
        bus.mosi_in = 1'b1;
        for (int d = 1; d <= LAT + 3; d++) begin
            step(1);
            if (d == 2) reset = 1'b1;
            if (d == 3) reset = 1'b0;
            // Reset lands on edge t0+3; the restarted filter completes LAT edges after release
            n_cmp++;
            if (bus.mosi_cond !== ((d >= LAT + 3) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL reset_mid_filter[+%0d]: mosi_cond got %b, expected %b",
                         d, bus.mosi_cond, (d >= LAT + 3) ? 1'b1 : 1'b0);
            end
        end
        bus.mosi_in = 1'b0;
        step(LAT + 2);
        n_cmp++;
        if (obs_q.size() !== 0) begin
            n_bad++; $display("FAIL reset_mid_filter_pulses: got %0d events, expected 0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_glitch();
        test_spi_frame();
        test_simultaneous();
        test_reset_mid_filter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
